// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant FSM.
//   state_t  : arbiter FSM states (IDLE, GRANT, GAP)
//   rr_next  : wrap-around increment of a requester index modulo n
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Next index after ptr in a ring of n requesters.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder.
// Scans req starting at index ptr, then ptr+1, ... wrapping modulo N, and
// reports the first set bit.
// Ports:
//   req   in  N    request vector
//   ptr   in  IDW  highest-priority index (must be < N)
//   valid out 1    some request is set
//   idx   out IDW  index of the winning requester (0 when !valid)
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    localparam logic [IDW:0] N_W = (IDW + 1)'(N);

    // cand[gi] is the requester index examined at priority rank gi;
    // rot[gi] is whether that requester is asking.
    logic [IDW-1:0] cand [N];
    logic [N-1:0]   rot;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [IDW:0] sum;
            logic [IDW:0] wrapped;
            // ptr < N, so one conditional subtract is a full modulo.
            assign sum      = {1'b0, ptr} + (IDW + 1)'(gi);
            assign wrapped  = (sum >= N_W) ? (sum - N_W) : sum;
            assign cand[gi] = wrapped[IDW-1:0];
            assign rot[gi]  = req[cand[gi]];
        end
    endgenerate

    // Scan from lowest rank last so the lowest-ranked hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/rr_grant_fsm.sv
// Moore round-robin arbiter: grants one requester at a time, holds the grant
// while the owner keeps requesting (up to MAX_HOLD cycles), and inserts one
// dead GAP cycle between owners. The last owner is ranked lowest at the next
// arbitration. All outputs decode registered state only.
// Ports:
//   clk     in  1    clock, rising edge
//   areset  in  1    asynchronous active-high reset
//   req     in  N    level-sensitive request vector
//   gnt     out N    one-hot grant, zero when no owner
//   gnt_id  out IDW  current owner index, holds last owner when gnt==0
//   busy    out 1    high while a grant is active
//   expired out 1    one-cycle pulse in the GAP following a forced release
module rr_grant_fsm
    import arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           areset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           expired
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    state_t         state_reg, state_next;
    logic [IDW-1:0] owner_reg, owner_next;
    logic [IDW-1:0] ptr_reg, ptr_next;
    logic [HW-1:0]  hold_reg, hold_next;
    logic           expired_flag_reg, expired_flag_next;

    logic           pick_valid;
    logic [IDW-1:0] pick_idx;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_reg        <= IDLE;
            owner_reg        <= '0;
            ptr_reg          <= '0;
            hold_reg         <= '0;
            expired_flag_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            owner_reg        <= owner_next;
            ptr_reg          <= ptr_next;
            hold_reg         <= hold_next;
            expired_flag_reg <= expired_flag_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        owner_next        = owner_reg;
        ptr_next          = ptr_reg;
        hold_next         = hold_reg;
        expired_flag_next = expired_flag_reg;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = GRANT;
                    owner_next = pick_idx;
                    hold_next  = HW'(1);
                end
            end
            GRANT: begin
                // A release on the same edge the limit is reached counts as
                // a normal release, so the req check comes first.
                if (!req[owner_reg]) begin
                    state_next        = GAP;
                    expired_flag_next = 1'b0;
                    ptr_next          = IDW'(rr_next(int'(owner_reg), N));
                end else if (hold_reg == HOLD_MAX) begin
                    state_next        = GAP;
                    expired_flag_next = 1'b1;
                    ptr_next          = IDW'(rr_next(int'(owner_reg), N));
                end else begin
                    hold_next = hold_reg + HW'(1);
                end
            end
            GAP: begin
                expired_flag_next = 1'b0;
                if (pick_valid) begin
                    state_next = GRANT;
                    owner_next = pick_idx;
                    hold_next  = HW'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next        = IDLE;
                expired_flag_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        gnt     = '0;
        busy    = 1'b0;
        expired = 1'b0;
        gnt_id  = owner_reg;
        if (state_reg == GRANT) begin
            gnt  = N'(1) << owner_reg;
            busy = 1'b1;
        end
        if (state_reg == GAP) begin
            expired = expired_flag_reg;
        end
    end

endmodule

// File: tb/tb_rr_grant_fsm.sv
// Self-checking bench for rr_grant_fsm. Two instances share one request
// vector: one with MAX_HOLD=8, one with MAX_HOLD=1. Each is compared every
// cycle against a behavioural model of owner/hold/gap bookkeeping.
module tb_rr_grant_fsm;

    localparam int N  = 4;
    localparam int HA = 8;
    localparam int HB = 1;

    logic         clk = 1'b0;
    logic         areset = 1'b1;
    logic [N-1:0] req = '0;

    logic [N-1:0] gnt_a, gnt_b;
    logic [1:0]   id_a, id_b;
    logic         busy_a, busy_b, exp_a, exp_b;

    int errors = 0;
    int checks = 0;

    rr_grant_fsm #(.N(N), .MAX_HOLD(HA)) dut_a (
        .clk(clk), .areset(areset), .req(req),
        .gnt(gnt_a), .gnt_id(id_a), .busy(busy_a), .expired(exp_a)
    );

    rr_grant_fsm #(.N(N), .MAX_HOLD(HB)) dut_b (
        .clk(clk), .areset(areset), .req(req),
        .gnt(gnt_b), .gnt_id(id_b), .busy(busy_b), .expired(exp_b)
    );

    always #5 clk = ~clk;

    // Reference model, one slot per instance.
    int max_hold [2] = '{HA, HB};
    bit has_owner [2];
    int owner     [2];
    int held      [2];
    int next_first[2];
    bit in_gap    [2];
    bit forced    [2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            has_owner[d] = 0; owner[d] = 0; held[d] = 0;
            next_first[d] = 0; in_gap[d] = 0; forced[d] = 0;
        end
    endfunction

    function automatic void model_step(input logic [N-1:0] r);
        for (int d = 0; d < 2; d++) begin
            if (has_owner[d]) begin
                if (!r[owner[d]] || held[d] >= max_hold[d]) begin
                    forced[d]     = r[owner[d]];
                    has_owner[d]  = 0;
                    in_gap[d]     = 1;
                    next_first[d] = (owner[d] + 1) % N;
                end else begin
                    held[d] = held[d] + 1;
                end
            end else begin
                int w;
                w = -1;
                for (int i = 0; i < N; i++) begin
                    int c;
                    c = (next_first[d] + i) % N;
                    if (w < 0 && r[c]) w = c;
                end
                in_gap[d] = 0;
                forced[d] = 0;
                if (w >= 0) begin
                    has_owner[d] = 1;
                    owner[d]     = w;
                    held[d]      = 1;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic [N-1:0] o_gnt, e_gnt;
            logic [1:0]   o_id;
            logic         o_busy, o_exp;
            o_gnt  = (d == 0) ? gnt_a  : gnt_b;
            o_id   = (d == 0) ? id_a   : id_b;
            o_busy = (d == 0) ? busy_a : busy_b;
            o_exp  = (d == 0) ? exp_a  : exp_b;
            e_gnt  = has_owner[d] ? (N'(1) << owner[d]) : '0;
            check($sformatf("gnt_%0d", d),     32'(o_gnt),  32'(e_gnt));
            check($sformatf("gnt_id_%0d", d),  32'(o_id),   32'(owner[d]));
            check($sformatf("busy_%0d", d),    32'(o_busy), 32'(has_owner[d]));
            check($sformatf("expired_%0d", d), 32'(o_exp),  32'(in_gap[d] && forced[d]));
        end
    endtask

    // Called at a negedge: apply req, take one rising edge, check at the
    // following negedge.
    task automatic tick(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        $display("t=%0t req=%b a:gnt=%b id=%0d exp=%b b:gnt=%b id=%0d exp=%b",
                 $time, r, gnt_a, id_a, exp_a, gnt_b, id_b, exp_b);
        check_all();
    endtask

    task automatic tick_n(input logic [N-1:0] r, input int n);
        for (int i = 0; i < n; i++) tick(r);
    endtask

    initial begin
        logic [N-1:0] r;
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        areset = 1'b0;

        // Reset mid-grant: outputs must drop before the next edge.
        tick_n(4'b0001, 3);
        #2 areset = 1'b1;
        #1;
        check("async_gnt_a",  32'(gnt_a),  32'h0);
        check("async_gnt_b",  32'(gnt_b),  32'h0);
        check("async_busy_a", 32'(busy_a), 32'h0);
        check("async_busy_b", 32'(busy_b), 32'h0);
        model_reset();
        req = '0;
        @(negedge clk);
        areset = 1'b0;
        tick(4'b0000);

        // Single requester.
        tick_n(4'b0010, 3);
        tick_n(4'b0000, 3);
        // Saturation.
        tick_n(4'b1111, 40);
        tick_n(4'b0000, 2);
        // Fairness with wrap.
        tick_n(4'b0101, 3);
        tick_n(4'b0100, 4);
        tick_n(4'b0001, 1);
        tick_n(4'b0101, 3);
        tick_n(4'b0000, 2);
        // Lone re-request across a forced release.
        tick_n(4'b1000, 10);
        tick_n(4'b0000, 3);
        // Two constant requesters (single-cycle grants on the second instance).
        tick_n(4'b0011, 8);
        tick_n(4'b0000, 2);

        // Random: each bit toggles with probability 1/4 per cycle.
        r = '0;
        for (int i = 0; i < 500; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            tick(r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_grant_fsm.md
Name: rr_grant_fsm

Overview:
- Moore-style round-robin arbiter FSM that shares one resource among N requesters.
- Grants one requester at a time and holds the grant while that requester keeps requesting, up to a burst limit.
- Inserts one dead cycle between owners.
- Sits in front of any shared single-owner datapath (bus, memory port, shared FSM) and drives its select/enable.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership (1..255).
- IDW, $clog2(N), width of gnt_id (derived, not overridable).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- areset  input  1  asynchronous, active-high reset.
- req  input  N  request vector, level-sensitive, bit i = requester i.
- gnt  output  N  one-hot grant, all-zero when no owner.
- gnt_id  output  IDW  index of current owner; holds last owner when gnt==0.
- busy  output  1  high while state==GRANT (equals |gnt).
- expired  output  1  one-cycle pulse during the GAP cycle that follows a forced (MAX_HOLD) release.

Behaviour:
- Reset (areset high, async):
  - state=IDLE, ptr=0, owner=0, hold_cnt=0.
  - gnt=0, gnt_id=0, busy=0, expired=0.
  - Reset asserted mid-grant drops gnt immediately (async), not at the next edge.
- State register: IDLE, GRANT, GAP.
- All outputs decoded from registered state/owner/flags only; no combinational path from req to any output.
- Arbitration (IDLE and GAP):
  - Winner = first set bit of req scanning ptr, ptr+1, ..., wrapping mod N.
  - If req==0 there is no winner.
- IDLE:
  - Winner exists -> GRANT next edge; owner=winner, hold_cnt=1.
  - Else stay IDLE.
  - Latency: req sampled high at edge k -> gnt high from edge k onward (visible in the cycle after the edge).
- GRANT:
  - gnt=1<<owner, busy=1.
  - req[owner]==0 -> GAP, expired_flag=0.
  - req[owner]==1 and hold_cnt==MAX_HOLD -> GAP, expired_flag=1.
  - Otherwise stay, hold_cnt+1.
  - On any exit: ptr=(owner+1) mod N, so the last owner gets lowest priority.
- GAP:
  - gnt=0, busy=0, expired=expired_flag. Always exactly one cycle.
  - Arbitrate as in IDLE. Winner -> GRANT with hold_cnt=1; else IDLE.
  - expired_flag clears on leaving GAP.
- hold_cnt:
  - Width $clog2(MAX_HOLD+1).
  - Never exceeds MAX_HOLD, so there is no wrap.
  - With MAX_HOLD=1, every grant lasts exactly one cycle.
- Owner stays requesting at forced release:
  - Goes to GAP. It is eligible again but ranks last.
  - If it is the only requester, it is re-granted after the single GAP cycle.
- Non-owner req changes during GRANT: ignored until the next arbitration.
- req[owner] falls on the same edge hold_cnt reaches MAX_HOLD: treated as normal release, expired=0.
- Illegal state encoding: next state is IDLE, gnt=0.

Decomposition:
- Package arb_pkg:
  - state_t enum {IDLE, GRANT, GAP}.
  - Function rr_next(ptr, N) for the wrap-around increment.
- Sub-module rr_pick: combinational rotating-priority encoder.
  - Inputs: req[N], ptr.
  - Outputs: valid, idx.
  - Instantiated once.
- Main module holds the state register, owner, ptr, hold_cnt and expired_flag.

Test Plan:
1. Reset mid-grant: req=0001 for 3 cycles, assert areset between edges -> gnt=0000, busy=0 immediately. After release with req=0000: state IDLE, gnt_id=0.
2. Single requester: req=0010 for 3 edges then 0000.
   - gnt=0010, gnt_id=1 for 3 cycles.
   - Then one GAP cycle (gnt=0, expired=0), then IDLE.
3. Saturation: req=1111 constant, MAX_HOLD=8.
   - Grant sequence 0001, 0010, 0100, 1000, 0001.
   - Each grant lasts exactly 8 cycles, separated by 1 GAP cycle with expired=1.
4. Round-robin fairness: req=0101, owner 0 drops req after 2 cycles, req becomes 0100.
   - GAP, then gnt=0100.
   - Then req=0101 after owner 2 releases -> next gnt=0001 (ptr=3 wraps to 0).
5. Lone re-request: req=1000 held 10 cycles, MAX_HOLD=8.
   - gnt=1000 for 8 cycles.
   - 1 GAP cycle with expired=1.
   - gnt=1000 for the remaining 1 cycle of the 10-cycle request; when req falls, a second GAP (expired=0) follows, then IDLE.
6. Boundary MAX_HOLD=1, req=0011 constant -> gnt alternates 0001, 0000, 0010, 0000, with expired=1 on each gap.
